counter_match_scheduler: RTL and testbench

COUNTER_MATCH_SCHEDULER -- requirements
Module: counter_match_scheduler

---
 rtl/counter_match_scheduler.sv | 174 +++++++++++++++++
 tb/tb_counter_match_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_match_scheduler.sv
// Two-player scheduler: arbitrates counter ownership in fixed RUN slices,
// programs the counter, and keeps per-player game scores until a match is won.
module counter_match_scheduler #(
    parameter int unsigned CNT_W        = 5,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned SLICE        = 8,
    parameter int unsigned MATCH_POINTS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         req,
    input  logic [1:0]         cmd0_mode,
    input  logic [1:0]         cmd1_mode,
    input  logic               cmd0_load,
    input  logic               cmd1_load,
    input  logic [CNT_W-1:0]   cmd0_value,
    input  logic [CNT_W-1:0]   cmd1_value,
    output logic [1:0]         gnt,
    output logic [1:0]         ctr_mode,
    output logic               ctr_init,
    output logic [CNT_W-1:0]   ctr_value,
    input  logic               ctr_gameover,
    input  logic [1:0]         ctr_who,
    output logic               owner,
    output logic [SCORE_W-1:0] p0_score,
    output logic [SCORE_W-1:0] p1_score,
    output logic               match_done
);

    localparam int unsigned        SLICE_W    = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] MATCH_PTS  = SCORE_W'(MATCH_POINTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_RUN,
        S_SCORE,
        S_MATCH_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               init_q, init_d;
    logic [CNT_W-1:0]   value_q, value_d;
    logic               owner_q, owner_d;
    logic               ptr_q, ptr_d;
    logic [SCORE_W-1:0] p0_q, p0_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic               done_q, done_d;
    logic [SLICE_W-1:0] slice_q, slice_d;
    logic [1:0]         who_q, who_d;

    logic [1:0]         gnt_c;
    logic               sel_c;
    logic               inc_p0_c;
    logic               inc_p1_c;

    // Next-state, grant and score update logic
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        value_d  = value_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        who_d    = who_q;
        slice_d  = '0;
        gnt_c    = 2'b00;
        inc_p0_c = 1'b0;
        inc_p1_c = 1'b0;

        // ptr_q names the player preferred when both request
        sel_c = req[1] & (~req[0] | ptr_q);

        case (state_q)
            S_IDLE, S_MATCH_OVER: begin
                if (start) begin
                    p0_d    = '0;
                    p1_d    = '0;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (|req) begin
                    gnt_c   = sel_c ? 2'b10 : 2'b01;
                    owner_d = sel_c;
                    ptr_d   = ~sel_c;
                    mode_d  = sel_c ? cmd1_mode  : cmd0_mode;
                    value_d = sel_c ? cmd1_value : cmd0_value;
                    state_d = (sel_c ? cmd1_load : cmd0_load) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ctr_gameover) begin
                    who_d   = ctr_who;
                    state_d = S_SCORE;
                end else if (slice_q == '0) begin
                    state_d = S_ARB;
                end else begin
                    slice_d = slice_q - SLICE_W'(1);
                end
            end
            S_SCORE: begin
                inc_p0_c = ((who_q == 2'b10) && !owner_q) || ((who_q == 2'b01) && owner_q);
                inc_p1_c = ((who_q == 2'b10) && owner_q)  || ((who_q == 2'b01) && !owner_q);
                if (inc_p0_c && (p0_q != SCORE_MAX)) begin
                    p0_d = p0_q + SCORE_W'(1);
                end
                if (inc_p1_c && (p1_q != SCORE_MAX)) begin
                    p1_d = p1_q + SCORE_W'(1);
                end
                state_d = ((p0_d == MATCH_PTS) || (p1_d == MATCH_PTS)) ? S_MATCH_OVER : S_ARB;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Slice counter reloads on every RUN entry
        if ((state_d == S_RUN) && (state_q != S_RUN)) begin
            slice_d = SLICE_LAST;
        end

        init_d = (state_d == S_LOAD);
        done_d = (state_d == S_MATCH_OVER);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            init_q  <= 1'b0;
            value_q <= '0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            p0_q    <= '0;
            p1_q    <= '0;
            done_q  <= 1'b0;
            slice_q <= '0;
            who_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            init_q  <= init_d;
            value_q <= value_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            done_q  <= done_d;
            slice_q <= slice_d;
            who_q   <= who_d;
        end
    end

    assign gnt        = gnt_c;
    assign ctr_mode   = mode_q;
    assign ctr_init   = init_q;
    assign ctr_value  = value_q;
    assign owner      = owner_q;
    assign p0_score   = p0_q;
    assign p1_score   = p1_q;
    assign match_done = done_q;

endmodule

// File: tb/tb_counter_match_scheduler.sv
// Bench for counter_match_scheduler: directed scenarios plus random traffic,
// checked every cycle against a phase/score model of the scheduler.
module tb_counter_match_scheduler;

    localparam int CNT_W        = 5;
    localparam int SCORE_W      = 4;
    localparam int SLICE        = 8;
    localparam int MATCH_POINTS = 3;
    localparam int SMAX         = (1 << SCORE_W) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_ARB   = 1;
    localparam int P_LOAD  = 2;
    localparam int P_RUN   = 3;
    localparam int P_SCORE = 4;
    localparam int P_OVER  = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         req;
    logic [1:0]         cmd0_mode, cmd1_mode;
    logic               cmd0_load, cmd1_load;
    logic [CNT_W-1:0]   cmd0_value, cmd1_value;
    logic [1:0]         gnt;
    logic [1:0]         ctr_mode;
    logic               ctr_init;
    logic [CNT_W-1:0]   ctr_value;
    logic               ctr_gameover;
    logic [1:0]         ctr_who;
    logic               owner;
    logic [SCORE_W-1:0] p0_score, p1_score;
    logic               match_done;

    int checks   = 0;
    int failures = 0;

    // Model: current phase, cycles left in the slice, latched command, scores
    int m_phase, m_left, m_mode, m_val, m_owner, m_next, m_who;
    int m_score[2];

    counter_match_scheduler #(
        .CNT_W(CNT_W), .SCORE_W(SCORE_W), .SLICE(SLICE), .MATCH_POINTS(MATCH_POINTS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .req(req),
        .cmd0_mode(cmd0_mode), .cmd1_mode(cmd1_mode),
        .cmd0_load(cmd0_load), .cmd1_load(cmd1_load),
        .cmd0_value(cmd0_value), .cmd1_value(cmd1_value),
        .gnt(gnt), .ctr_mode(ctr_mode), .ctr_init(ctr_init), .ctr_value(ctr_value),
        .ctr_gameover(ctr_gameover), .ctr_who(ctr_who), .owner(owner),
        .p0_score(p0_score), .p1_score(p1_score), .match_done(match_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int pick();
        if (req == 2'b11) return m_next;
        return req[1] ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_phase    = P_IDLE;
        m_left     = 0;
        m_mode     = 0;
        m_val      = 0;
        m_owner    = 0;
        m_next     = 0;
        m_who      = 0;
        m_score[0] = 0;
        m_score[1] = 0;
    endtask

    task automatic model_step();
        int p;
        int w;
        case (m_phase)
            P_IDLE, P_OVER: begin
                if (start) begin
                    m_score[0] = 0;
                    m_score[1] = 0;
                    m_phase    = P_ARB;
                end
            end
            P_ARB: begin
                if (req != 2'b00) begin
                    p       = pick();
                    m_owner = p;
                    m_next  = 1 - p;
                    m_mode  = p ? int'(cmd1_mode) : int'(cmd0_mode);
                    m_val   = p ? int'(cmd1_value) : int'(cmd0_value);
                    if (p ? cmd1_load : cmd0_load) begin
                        m_phase = P_LOAD;
                    end else begin
                        m_phase = P_RUN;
                        m_left  = SLICE;
                    end
                end
            end
            P_LOAD: begin
                m_phase = P_RUN;
                m_left  = SLICE;
            end
            P_RUN: begin
                if (ctr_gameover) begin
                    m_who   = int'(ctr_who);
                    m_phase = P_SCORE;
                end else if (m_left == 1) begin
                    m_phase = P_ARB;
                end else begin
                    m_left--;
                end
            end
            P_SCORE: begin
                w = -1;
                if (m_who == 2) w = m_owner;
                else if (m_who == 1) w = 1 - m_owner;
                if (w >= 0 && m_score[w] < SMAX) m_score[w]++;
                m_phase = (m_score[0] == MATCH_POINTS || m_score[1] == MATCH_POINTS) ? P_OVER : P_ARB;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        int exp_gnt;
        exp_gnt = 0;
        if (m_phase == P_ARB && req != 2'b00) exp_gnt = (pick() == 1) ? 2 : 1;
        chk("gnt", gnt, exp_gnt);
        chk("ctr_init", ctr_init, int'(m_phase == P_LOAD));
        chk("match_done", match_done, int'(m_phase == P_OVER));
        chk("owner", owner, m_owner);
        chk("p0_score", p0_score, m_score[0]);
        chk("p1_score", p1_score, m_score[1]);
        if (m_phase == P_RUN)  chk("ctr_mode", ctr_mode, m_mode);
        if (m_phase == P_LOAD) chk("ctr_value", ctr_value, m_val);
    endtask

    // Called just after a falling edge with inputs set; ends at the next falling edge
    task automatic tick();
        #1;
        check_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        model_reset();
        chk("rst_ctr_init", ctr_init, 0);
        chk("rst_ctr_mode", ctr_mode, 0);
        chk("rst_ctr_value", ctr_value, 0);
        chk("rst_owner", owner, 0);
        chk("rst_p0", p0_score, 0);
        chk("rst_p1", p1_score, 0);
        chk("rst_match_done", match_done, 0);
        chk("rst_gnt", gnt, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic quiet_inputs();
        start        = 1'b0;
        req          = 2'b00;
        cmd0_mode    = 2'b00;
        cmd1_mode    = 2'b00;
        cmd0_load    = 1'b0;
        cmd1_load    = 1'b0;
        cmd0_value   = '0;
        cmd1_value   = '0;
        ctr_gameover = 1'b0;
        ctr_who      = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request with preload, then a full slice
        start = 1'b1; tick(); start = 1'b0;
        req = 2'b01; cmd0_mode = 2'b01; cmd0_load = 1'b1; cmd0_value = 5'd18;
        #1 chk("r36_gnt", gnt, 1);
        tick(); req = 2'b00;
        #1 chk("r36_init", ctr_init, 1);
        chk("r36_value", ctr_value, 18);
        tick();
        for (int i = 0; i < SLICE; i++) begin
            #1 chk("r36_mode", ctr_mode, 1);
            chk("r36_init_run", ctr_init, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1 chk("r36_arb_idle_gnt", gnt, 0);
            tick();
        end
        req = 2'b10; cmd1_mode = 2'b11; cmd1_load = 1'b0;
        #1 chk("r36_arb_gnt", gnt, 2);
        tick(); req = 2'b00;
        for (int i = 0; i < SLICE; i++) tick();

        // Round-robin with both requesting from reset
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        req = 2'b11; cmd0_load = 1'b0; cmd1_load = 1'b0; cmd0_mode = 2'b10; cmd1_mode = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1 chk("r37_gnt", gnt, (k == 1) ? 2 : 1);
            tick();
            for (int i = 0; i < SLICE; i++) begin
                #1 chk("r37_owner", owner, (k == 1) ? 1 : 0);
                tick();
            end
        end

        // Game over coinciding with slice expiry, owner 1
        #1 chk("r38_gnt", gnt, 2);
        tick(); req = 2'b00;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                ctr_gameover = 1'b1;
                ctr_who      = 2'b10;
            end
            tick();
        end
        #1 chk("r38_p1_in_score", p1_score, 0);
        tick();
        ctr_gameover = 1'b0; ctr_who = 2'b00;
        #1 chk("r38_p1", p1_score, 1);
        chk("r38_p0", p0_score, 0);
        chk("r38_done", match_done, 0);
        req = 2'b01;
        #1 chk("r38_arb_gnt", gnt, 1);
        tick(); req = 2'b00;
        tick();

        // Match won by player 1 through losses of owner 0
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int g = 0; g < MATCH_POINTS; g++) begin
            req = 2'b01; cmd0_load = 1'b0;
            #1 chk("r39_gnt", gnt, 1);
            tick(); req = 2'b00;
            ctr_gameover = 1'b1; ctr_who = 2'b01;
            #1 chk("r39_owner", owner, 0);
            tick();
            tick();
            ctr_gameover = 1'b0; ctr_who = 2'b00;
        end
        #1 chk("r39_p1", p1_score, 3);
        chk("r39_p0", p0_score, 0);
        chk("r39_done", match_done, 1);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("r39_over_gnt", gnt, 0);
            chk("r39_over_done", match_done, 1);
            tick();
        end
        req = 2'b00; start = 1'b1; tick(); start = 1'b0;
        #1 chk("r39_clr_p0", p0_score, 0);
        chk("r39_clr_p1", p1_score, 0);
        chk("r39_clr_done", match_done, 0);

        // Idle arbitration
        for (int i = 0; i < 20; i++) begin
            #1 chk("r41_gnt", gnt, 0);
            chk("r41_init", ctr_init, 0);
            chk("r41_p0", p0_score, 0);
            chk("r41_p1", p1_score, 0);
            tick();
        end

        // Reset during LOAD
        req = 2'b10; cmd1_load = 1'b1; cmd1_value = 5'd7;
        #1 chk("r40_gnt", gnt, 2);
        tick(); req = 2'b00;
        #1 chk("r40_init", ctr_init, 1);
        chk("r40_owner", owner, 1);
        do_reset();
        req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1 chk("r35_idle_gnt", gnt, 0);
            tick();
        end
        req = 2'b00;

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                start        = ($urandom_range(0, 15) == 0);
                req          = 2'($urandom_range(0, 3));
                cmd0_mode    = 2'($urandom_range(0, 3));
                cmd1_mode    = 2'($urandom_range(0, 3));
                cmd0_load    = 1'($urandom_range(0, 1));
                cmd1_load    = 1'($urandom_range(0, 1));
                cmd0_value   = CNT_W'($urandom_range(0, 31));
                cmd1_value   = CNT_W'($urandom_range(0, 31));
                ctr_gameover = ($urandom_range(0, 5) == 0);
                ctr_who      = 2'($urandom_range(0, 3));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
